// File: rtl/layer_scan_sched_if.sv
// Scheduler-side bundle: RAM read port, pixel stream to the bit encoder, chain select and frame status.
interface layer_scan_sched_if #(
  parameter int LAYER_NUM = 8,
  parameter int WORD_NUM  = 64
);
  localparam int LW = $clog2(LAYER_NUM);
  localparam int WW = $clog2(WORD_NUM);

  logic                 frame_rdy_in;
  logic                 ram_rd_en_out;
  logic [LW+WW:0]       ram_rd_addr_out;
  logic [23:0]          ram_rd_data_in;
  logic                 pix_vld_out;
  logic [23:0]          pix_data_out;
  logic                 pix_rdy_in;
  logic                 enc_busy_in;
  logic [LAYER_NUM-1:0] layer_en_out;
  logic                 disp_bank_out;
  logic                 busy_out;
  logic                 frame_done_out;

  modport master (
    input  frame_rdy_in, ram_rd_data_in, pix_rdy_in, enc_busy_in,
    output ram_rd_en_out, ram_rd_addr_out, pix_vld_out, pix_data_out,
           layer_en_out, disp_bank_out, busy_out, frame_done_out
  );

  modport slave (
    output frame_rdy_in, ram_rd_data_in, pix_rdy_in, enc_busy_in,
    input  ram_rd_en_out, ram_rd_addr_out, pix_vld_out, pix_data_out,
           layer_en_out, disp_bank_out, busy_out, frame_done_out
  );
endinterface

// File: rtl/layer_scan_sched.sv
// Double-buffered layer scan: swaps bank per frame, streams each layer's words to the encoder, then holds the latch gap.
// Each pixel costs RD/CAP/SEND (>=3 cycles); SEND holds pix_data_out until pix_rdy_in.
module layer_scan_sched #(
  parameter int LAYER_NUM = 8,
  parameter int WORD_NUM  = 64,
  parameter int LATCH_CYC = 4000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  layer_scan_sched_if.master bus
);
  localparam int LW  = $clog2(LAYER_NUM);
  localparam int WW  = $clog2(WORD_NUM);
  localparam int LCW = $clog2(LATCH_CYC + 1);
  localparam logic [LW-1:0]  LAYER_LAST = LW'(LAYER_NUM - 1);
  localparam logic [WW-1:0]  WORD_LAST  = WW'(WORD_NUM - 1);
  localparam logic [LCW-1:0] LATCH_LOAD = LCW'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SWAP, S_RD, S_CAP, S_SEND, S_DRAIN, S_LATCH, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            bank_q, bank_d;
  logic            pend_q, pend_d;
  logic            vld_q, vld_d;
  logic [23:0]     data_q, data_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [WW-1:0]   word_q, word_d;
  logic [LCW-1:0]  latch_q, latch_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      layer_q <= '0;
      word_q  <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      layer_q <= layer_d;
      word_q  <= word_d;
      latch_q <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    data_d  = data_q;
    layer_d = layer_q;
    word_d  = word_q;
    latch_d = latch_q;

    // A frame finishing while we scan is remembered once; IDLE/DONE act on it directly.
    if (state_q == S_SWAP) begin
      pend_d = bus.frame_rdy_in;
    end else if (state_q != S_IDLE && state_q != S_DONE) begin
      pend_d = pend_q | bus.frame_rdy_in;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frame_rdy_in || pend_q) state_d = S_SWAP;
      end
      S_SWAP: begin
        bank_d  = ~bank_q;
        layer_d = '0;
        word_d  = '0;
        state_d = S_RD;
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = bus.ram_rd_data_in;
        vld_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.pix_rdy_in) begin
          vld_d = 1'b0;
          if (word_q == WORD_LAST) begin
            word_d  = '0;
            state_d = S_DRAIN;
          end else begin
            word_d  = word_q + WW'(1);
            state_d = S_RD;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.enc_busy_in) begin
          latch_d = LATCH_LOAD;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (latch_q == '0) begin
          if (layer_q == LAYER_LAST) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = S_RD;
          end
        end else begin
          latch_d = latch_q - LCW'(1);
        end
      end
      S_DONE: begin
        state_d = (pend_q || bus.frame_rdy_in) ? S_SWAP : S_IDLE;
      end
    endcase
  end

  logic layer_act;
  assign layer_act = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_SEND) ||
                     (state_q == S_DRAIN) || (state_q == S_LATCH);

  assign bus.ram_rd_en_out   = (state_q == S_RD);
  assign bus.ram_rd_addr_out = {bank_q, layer_q, word_q};
  assign bus.pix_vld_out     = vld_q;
  assign bus.pix_data_out    = data_q;
  assign bus.layer_en_out    = layer_act ? ({{(LAYER_NUM-1){1'b0}}, 1'b1} << layer_q) : '0;
  assign bus.disp_bank_out   = bank_q;
  assign bus.busy_out        = (state_q != S_IDLE);
  assign bus.frame_done_out  = (state_q == S_DONE);
endmodule

// File: tb/tb_layer_scan_sched.sv
// Bench for layer_scan_sched: registered RAM model, pixel scoreboard and per-scenario checks.
module tb_layer_scan_sched;
  localparam int LN = 8;
  localparam int WN = 64;
  localparam int L  = 40;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  layer_scan_sched_if #(.LAYER_NUM(LN), .WORD_NUM(WN)) bus ();
  layer_scan_sched #(.LAYER_NUM(LN), .WORD_NUM(WN), .LATCH_CYC(L)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int          vec = 0;
  int          errs = 0;
  int          rd_cnt = 0;
  int          xfer_cnt = 0;
  int          cyc = 0;
  logic        exp_bank = 1'b0;
  logic        last_xfer = 1'b0;
  logic [23:0] sb_q[$];

  function automatic logic [23:0] ram_word(input logic [9:0] a);
    return {4'hA, a, a ^ 10'h3C5};
  endfunction

  function automatic logic [46:0] all_outs();
    return {bus.ram_rd_en_out, bus.ram_rd_addr_out, bus.pix_vld_out, bus.pix_data_out,
            bus.layer_en_out, bus.disp_bank_out, bus.busy_out, bus.frame_done_out};
  endfunction

  // One clock: score reads/transfers seen before the edge, then model the 1-cycle RAM.
  task automatic tick();
    logic        en, xf;
    logic [9:0]  a, exp_a;
    logic [7:0]  exp_le;
    logic [23:0] exp_d;
    en = bus.ram_rd_en_out;
    a  = bus.ram_rd_addr_out;
    xf = bus.pix_vld_out && bus.pix_rdy_in;
    if (en) begin
      exp_a  = {exp_bank, rd_cnt[8:0]};
      exp_le = 8'b1 << rd_cnt[8:6];
      vec++;
      if (a !== exp_a || bus.layer_en_out !== exp_le) begin
        errs++;
        $display("FAIL rd_addr: addr %h layer_en %h, expected addr %h layer_en %h", a, bus.layer_en_out, exp_a, exp_le);
      end
      sb_q.push_back(ram_word(a));
      rd_cnt++;
    end
    if (xf) begin
      vec++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL pix_extra: pixel %h transferred with none outstanding", bus.pix_data_out);
      end else begin
        exp_d = sb_q.pop_front();
        if (bus.pix_data_out !== exp_d) begin
          errs++;
          $display("FAIL pix_data: got %h expected %h", bus.pix_data_out, exp_d);
        end
      end
      xfer_cnt++;
    end
    @(posedge clk_in);
    #1;
    bus.ram_rd_data_in = en ? ram_word(a) : 24'($urandom);
    last_xfer = xf;
    cyc++;
  endtask

  task automatic start_frame();
    exp_bank = ~exp_bank;
    rd_cnt   = 0;
    xfer_cnt = 0;
    bus.frame_rdy_in = 1'b1;
    tick();
    bus.frame_rdy_in = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_in = 1'b1;
    bus.frame_rdy_in   = 1'b0;
    bus.ram_rd_data_in = '0;
    bus.pix_rdy_in     = 1'b0;
    bus.enc_busy_in    = 1'b0;
    @(posedge clk_in);
    #1;
    vec++;
    if (all_outs() !== '0) begin errs++; $display("FAIL reset_outs: got %h expected 0", all_outs()); end
    rst_in = 1'b0;
    bad = 0;
    repeat (5) begin tick(); if (bus.busy_out !== 1'b0 || bus.ram_rd_en_out !== 1'b0) bad++; end
    vec++;
    if (bad != 0 || bus.disp_bank_out !== 1'b0) begin
      errs++; $display("FAIL reset_idle: %0d active cycles, bank %b, expected 0 and 0", bad, bus.disp_bank_out);
    end
  endtask

  task automatic test_single_frame();
    int prev, g, bad_gap, done_cnt, post;
    prev = -1; bad_gap = 0; done_cnt = 0; post = 0;
    bus.pix_rdy_in = 1'b1; bus.enc_busy_in = 1'b0;
    start_frame();
    vec++;
    if (bus.busy_out !== 1'b1 || bus.disp_bank_out !== 1'b0) begin
      errs++; $display("FAIL swap_cycle: busy %b bank %b, expected 1 and 0", bus.busy_out, bus.disp_bank_out);
    end
    for (int i = 0; i < 6000 && post < 20; i++) begin
      if (bus.ram_rd_en_out) begin
        if (rd_cnt == 0) begin
          vec++;
          if (bus.disp_bank_out !== 1'b1 || bus.ram_rd_addr_out !== 10'h200) begin
            errs++; $display("FAIL first_read: bank %b addr %h, expected 1 and 200", bus.disp_bank_out, bus.ram_rd_addr_out);
          end
        end
        if (prev >= 0) begin
          g = cyc - prev;
          if (rd_cnt % WN == 0) begin
            vec++;
            if (g != L + 4) begin errs++; $display("FAIL latch_gap: %0d cycles between layers, expected %0d", g, L + 4); end
          end else if (g != 3) bad_gap++;
        end
        prev = cyc;
      end
      if (bus.frame_done_out) begin
        done_cnt++;
        vec++;
        if (bus.layer_en_out !== 8'h00 || bus.busy_out !== 1'b1) begin
          errs++; $display("FAIL done_state: layer_en %h busy %b, expected 00 and 1", bus.layer_en_out, bus.busy_out);
        end
      end
      if (done_cnt > 0) post++;
      tick();
    end
    vec++;
    if (done_cnt != 1) begin errs++; $display("FAIL done_pulses: got %0d expected 1", done_cnt); end
    vec++;
    if (rd_cnt != 512 || sb_q.size() != 0) begin
      errs++; $display("FAIL frame_reads: %0d reads %0d pending, expected 512 and 0", rd_cnt, sb_q.size());
    end
    vec++;
    if (bad_gap != 0) begin errs++; $display("FAIL pixel_gap: %0d gaps not 3 cycles, expected 0", bad_gap); end
    vec++;
    if (bus.busy_out !== 1'b0 || bus.layer_en_out !== 8'h00) begin
      errs++; $display("FAIL after_frame: busy %b layer_en %h, expected 0 and 00", bus.busy_out, bus.layer_en_out);
    end
  endtask

  task automatic test_backpressure();
    bit          hooked;
    int          bad;
    logic [23:0] held, exp_d;
    hooked = 0;
    bus.pix_rdy_in = 1'b1;
    start_frame();
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) begin
      if (!hooked && bus.ram_rd_en_out && rd_cnt == 2 * WN + 5) begin
        hooked = 1;
        exp_d = ram_word({exp_bank, 9'(2 * WN + 5)});
        bus.pix_rdy_in = 1'b0;
        tick();
        tick();
        held = bus.pix_data_out;
        vec++;
        if (bus.pix_vld_out !== 1'b1 || held !== exp_d) begin
          errs++; $display("FAIL bp_data: vld %b data %h, expected 1 and %h", bus.pix_vld_out, held, exp_d);
        end
        bad = 0;
        repeat (8) begin
          tick();
          if (bus.pix_vld_out !== 1'b1 || bus.pix_data_out !== held || bus.ram_rd_en_out !== 1'b0) bad++;
        end
        vec++;
        if (bad != 0) begin errs++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad); end
        bus.pix_rdy_in = 1'b1;
      end else tick();
    end
    vec++;
    if (!bus.frame_done_out || rd_cnt != 512 || sb_q.size() != 0) begin
      errs++; $display("FAIL bp_frame: done %b reads %0d pending %0d, expected 1 512 0", bus.frame_done_out, rd_cnt, sb_q.size());
    end
  endtask

  task automatic test_pending_merge();
    bit hooked;
    int bad;
    hooked = 0;
    start_frame();
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) begin
      if (!hooked && bus.ram_rd_en_out && rd_cnt == 4 * WN + 3) begin
        hooked = 1;
        repeat (3) begin
          bus.frame_rdy_in = 1'b1; tick();
          bus.frame_rdy_in = 1'b0; tick(); tick();
        end
      end else tick();
    end
    vec++;
    if (!bus.frame_done_out || rd_cnt != 512 || sb_q.size() != 0 || bus.disp_bank_out !== 1'b1) begin
      errs++; $display("FAIL merge_frame1: done %b reads %0d bank %b, expected 1 512 1", bus.frame_done_out, rd_cnt, bus.disp_bank_out);
    end
    exp_bank = 1'b0; rd_cnt = 0;
    tick();
    vec++;
    if (bus.busy_out !== 1'b1 || bus.frame_done_out !== 1'b0) begin
      errs++; $display("FAIL merge_swap: busy %b done %b, expected 1 and 0", bus.busy_out, bus.frame_done_out);
    end
    tick();
    vec++;
    if (bus.disp_bank_out !== 1'b0) begin errs++; $display("FAIL merge_bank: got %b expected 0", bus.disp_bank_out); end
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) tick();
    vec++;
    if (!bus.frame_done_out || rd_cnt != 512 || sb_q.size() != 0) begin
      errs++; $display("FAIL merge_frame2: done %b reads %0d, expected 1 512", bus.frame_done_out, rd_cnt);
    end
    tick();
    bad = 0;
    repeat (100) begin if (bus.busy_out !== 1'b0 || bus.ram_rd_en_out !== 1'b0) bad++; tick(); end
    vec++;
    if (bad != 0) begin errs++; $display("FAIL merge_extra: %0d busy cycles after second frame, expected 0", bad); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    int bad;
    seen = 0;
    bus.pix_rdy_in = 1'b0;
    start_frame();
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.pix_vld_out; end
    vec++;
    if (!seen || bus.disp_bank_out !== 1'b1) begin
      errs++; $display("FAIL rst_setup: vld %b bank %b, expected 1 and 1", seen, bus.disp_bank_out);
    end
    rst_in = 1'b1;
    #1;
    vec++;
    if (all_outs() !== '0) begin errs++; $display("FAIL rst_async: got %h expected 0", all_outs()); end
    @(posedge clk_in);
    #1;
    vec++;
    if (all_outs() !== '0) begin errs++; $display("FAIL rst_edge: got %h expected 0", all_outs()); end
    rst_in = 1'b0;
    sb_q.delete();
    exp_bank = 1'b0;
    bus.pix_rdy_in = 1'b1;
    bad = 0;
    repeat (10) begin tick(); if (bus.busy_out !== 1'b0 || bus.frame_done_out !== 1'b0 || bus.ram_rd_en_out !== 1'b0) bad++; end
    vec++;
    if (bad != 0 || bus.disp_bank_out !== 1'b0) begin
      errs++; $display("FAIL rst_release: %0d active cycles bank %b, expected 0 and 0", bad, bus.disp_bank_out);
    end
  endtask

  task automatic test_drain();
    bit hooked;
    int bad, n;
    hooked = 0;
    start_frame();
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) begin
      if (!hooked && last_xfer && xfer_cnt == 4 * WN) begin
        hooked = 1;
        bus.enc_busy_in = 1'b1;
        bad = 0;
        repeat (200) begin
          tick();
          if (bus.ram_rd_en_out !== 1'b0 || bus.layer_en_out !== 8'h08) bad++;
        end
        vec++;
        if (bad != 0) begin errs++; $display("FAIL drain_hold: %0d bad cycles while busy, expected 0", bad); end
        bus.enc_busy_in = 1'b0;
        n = 0;
        while (!bus.ram_rd_en_out && n < L + 10) begin tick(); n++; end
        vec++;
        if (n != L + 1) begin errs++; $display("FAIL drain_latch: next read %0d cycles after busy fell, expected %0d", n, L + 1); end
      end else tick();
    end
    vec++;
    if (!bus.frame_done_out || rd_cnt != 512 || sb_q.size() != 0) begin
      errs++; $display("FAIL drain_frame: done %b reads %0d pending %0d, expected 1 512 0", bus.frame_done_out, rd_cnt, sb_q.size());
    end
  endtask

  task automatic test_done_boundary();
    int bad;
    start_frame();
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) tick();
    vec++;
    if (!bus.frame_done_out || rd_cnt != 512) begin
      errs++; $display("FAIL bound_frame1: done %b reads %0d, expected 1 512", bus.frame_done_out, rd_cnt);
    end
    bus.frame_rdy_in = 1'b1;
    exp_bank = 1'b1; rd_cnt = 0;
    tick();
    bus.frame_rdy_in = 1'b0;
    vec++;
    if (bus.busy_out !== 1'b1 || bus.frame_done_out !== 1'b0) begin
      errs++; $display("FAIL bound_swap: busy %b done %b, expected 1 and 0", bus.busy_out, bus.frame_done_out);
    end
    tick();
    vec++;
    if (bus.disp_bank_out !== 1'b1 || bus.ram_rd_en_out !== 1'b1) begin
      errs++; $display("FAIL bound_bank: bank %b rd_en %b, expected 1 and 1", bus.disp_bank_out, bus.ram_rd_en_out);
    end
    for (int i = 0; i < 6000 && !bus.frame_done_out; i++) tick();
    tick();
    bad = 0;
    repeat (30) begin if (bus.busy_out !== 1'b0) bad++; tick(); end
    vec++;
    if (rd_cnt != 512 || sb_q.size() != 0 || bad != 0) begin
      errs++; $display("FAIL bound_frame2: reads %0d busy cycles %0d, expected 512 and 0", rd_cnt, bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_pending_merge();
    test_reset_mid_frame();
    test_drain();
    test_done_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
